// File: rtl/pb_cell_writer.sv
// pb_cell_writer: cuts packets into 64-byte cells, writes them to the buffer, links the chain, emits one descriptor per packet.
module pb_cell_writer #(
  parameter int CELL_ID_W = 20,
  parameter int DATA_W    = 512,
  parameter int LEN_W     = 14,
  parameter int MAX_LEN   = 9216
) (
  input  logic                 clk_dp,
  input  logic                 rst_dp_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATA_W-1:0]    in_data,
  input  logic                 in_sop,
  input  logic                 in_eop,
  input  logic [6:0]           in_bytes,
  output logic                 alloc_req,
  input  logic                 alloc_valid,
  input  logic [CELL_ID_W-1:0] alloc_id,
  output logic                 wr_valid,
  input  logic                 wr_ready,
  output logic [CELL_ID_W-1:0] wr_cell_id,
  output logic [DATA_W-1:0]    wr_data,
  output logic                 wr_eof,
  output logic                 lnk_valid,
  output logic [CELL_ID_W-1:0] lnk_cell_id,
  output logic [CELL_ID_W-1:0] lnk_next_id,
  output logic                 desc_valid,
  input  logic                 desc_ready,
  output logic [CELL_ID_W-1:0] desc_head_id,
  output logic [CELL_ID_W-1:0] desc_tail_id,
  output logic [LEN_W-1:0]     desc_len,
  output logic [CELL_ID_W-1:0] desc_ncells,
  output logic                 desc_err,
  output logic [31:0]          stray_cnt
);
  typedef enum logic [1:0] {IDLE, PKT, DROP, DESC} state_t;
  state_t state, state_n;
  logic [CELL_ID_W-1:0] head, tail, ncells;
  logic [LEN_W-1:0] len;
  logic [LEN_W:0] add, sum;
  logic [31:0] stray;
  logic err, lnk_tail, acc, ovf, stored;
  always_ff @(posedge clk_dp or negedge rst_dp_n)
    if (!rst_dp_n) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (acc && in_sop) state_n = in_eop ? DESC : PKT;
      PKT:     if (acc) state_n = in_eop ? DESC : ovf ? DROP : PKT;
      DROP:    if (acc && in_eop) state_n = DESC;
      default: if (desc_ready) state_n = IDLE;
    endcase
  end
  // Overflow is judged one bit wider than len so a long packet can never wrap past MAX_LEN.
  always_comb begin
    add = in_eop ? (LEN_W+1)'(in_bytes) : (LEN_W+1)'(64);
    sum = {1'b0, len} + add;
    ovf = (state == PKT) && (sum > (LEN_W+1)'(MAX_LEN));
    in_ready = rst_dp_n && ((state == IDLE || state == PKT) ? alloc_valid && wr_ready : state == DROP);
    acc = in_valid && in_ready;
    stored = acc && ((state == IDLE && in_sop) || (state == PKT && !ovf));
    alloc_req = stored;
    wr_valid = stored;
    wr_cell_id = alloc_id;
    wr_data = in_data;
    wr_eof = in_eop;
    lnk_valid = lnk_tail || (state == PKT && stored);
    lnk_cell_id = tail;
    lnk_next_id = lnk_tail ? '1 : alloc_id;
    desc_valid = state == DESC;
    desc_head_id = head;
    desc_tail_id = tail;
    desc_len = len;
    desc_ncells = ncells;
    desc_err = err;
    stray_cnt = stray;
  end
  always_ff @(posedge clk_dp or negedge rst_dp_n)
    if (!rst_dp_n) begin
      head <= '0;
      tail <= '0;
      ncells <= '0;
      len <= '0;
      err <= 1'b0;
      lnk_tail <= 1'b0;
      stray <= '0;
    end else begin
      lnk_tail <= state_n == DESC && state != DESC;
      if (state == IDLE && acc && !in_sop && stray != '1) stray <= stray + 32'd1;
      if (stored && state == IDLE) head <= alloc_id;
      if (stored) begin
        tail <= alloc_id;
        len <= state == IDLE ? add[LEN_W-1:0] : sum[LEN_W-1:0];
        ncells <= state == IDLE ? CELL_ID_W'(1) : ncells + CELL_ID_W'(1);
      end
      if (acc && ovf) err <= 1'b1;
      else if (state == DESC && desc_ready) err <= 1'b0;
    end
endmodule

// File: tb/tb_pb_cell_writer.sv
// tb_pb_cell_writer: directed vector table, hand-written corner sequences and a randomized run against a packet-level model.
module tb_pb_cell_writer;
  localparam int IW = 20, DW = 512, LW = 14, MAXL = 9216;
  localparam logic [IW-1:0] EOC = '1;
  logic clk_dp = 1'b0, rst_dp_n = 1'b0;
  logic in_valid = 1'b0, in_sop = 1'b0, in_eop = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic [6:0] in_bytes = 7'd64;
  logic alloc_valid = 1'b0, wr_ready = 1'b0, desc_ready = 1'b0;
  logic [IW-1:0] alloc_id = '0;
  logic in_ready, alloc_req, wr_valid, wr_eof, lnk_valid, desc_valid, desc_err;
  logic [IW-1:0] wr_cell_id, lnk_cell_id, lnk_next_id, desc_head_id, desc_tail_id, desc_ncells;
  logic [DW-1:0] wr_data;
  logic [LW-1:0] desc_len;
  logic [31:0] stray_cnt;
  logic s_in_ready, s_alloc_req, s_wr_valid, s_wr_eof, s_lnk_valid, s_desc_valid, s_desc_err;
  logic [IW-1:0] s_wr_cell_id, s_lnk_cell_id, s_lnk_next_id, s_desc_head_id, s_desc_tail_id, s_desc_ncells;
  logic [DW-1:0] s_wr_data;
  logic [LW-1:0] s_desc_len;
  logic [31:0] s_stray_cnt;

  pb_cell_writer u0 (
    .clk_dp(clk_dp), .rst_dp_n(rst_dp_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_sop(in_sop), .in_eop(in_eop), .in_bytes(in_bytes), .alloc_req(alloc_req), .alloc_valid(alloc_valid),
    .alloc_id(alloc_id), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_cell_id(wr_cell_id), .wr_data(wr_data),
    .wr_eof(wr_eof), .lnk_valid(lnk_valid), .lnk_cell_id(lnk_cell_id), .lnk_next_id(lnk_next_id),
    .desc_valid(desc_valid), .desc_ready(desc_ready), .desc_head_id(desc_head_id), .desc_tail_id(desc_tail_id),
    .desc_len(desc_len), .desc_ncells(desc_ncells), .desc_err(desc_err), .stray_cnt(stray_cnt));

  pb_cell_writer #(.MAX_LEN(128)) u1 (
    .clk_dp(clk_dp), .rst_dp_n(rst_dp_n), .in_valid(in_valid), .in_ready(s_in_ready), .in_data(in_data),
    .in_sop(in_sop), .in_eop(in_eop), .in_bytes(in_bytes), .alloc_req(s_alloc_req), .alloc_valid(alloc_valid),
    .alloc_id(alloc_id), .wr_valid(s_wr_valid), .wr_ready(wr_ready), .wr_cell_id(s_wr_cell_id), .wr_data(s_wr_data),
    .wr_eof(s_wr_eof), .lnk_valid(s_lnk_valid), .lnk_cell_id(s_lnk_cell_id), .lnk_next_id(s_lnk_next_id),
    .desc_valid(s_desc_valid), .desc_ready(desc_ready), .desc_head_id(s_desc_head_id), .desc_tail_id(s_desc_tail_id),
    .desc_len(s_desc_len), .desc_ncells(s_desc_ncells), .desc_err(s_desc_err), .stray_cnt(s_stray_cnt));

  always #5 clk_dp = ~clk_dp;

  int errors = 0, checks = 0;
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask

  typedef struct {
    logic v, sop, eop; logic [6:0] bytes; logic [IW-1:0] aid; logic av;
    logic rdy, wr, eof, lnk; logic [IW-1:0] lc, ln;
    logic dv; logic [IW-1:0] hd, tl; logic [LW-1:0] len; logic [IW-1:0] nc; logic err;
  } vec_t;
  vec_t tbl[14];

  typedef struct {logic [IW-1:0] id; logic [DW-1:0] d; logic eof;} wr_t;
  typedef struct {logic [IW-1:0] c, n;} lk_t;
  typedef struct {logic [IW-1:0] h, t; logic [LW-1:0] len; logic [IW-1:0] nc; logic err;} ds_t;
  wr_t ewr[$];
  lk_t elk[$];
  ds_t eds[$];
  wr_t mw;
  lk_t ml;
  ds_t md;
  logic mon_en = 1'b0;
  int pops, exp_stray, nid;

  function automatic logic [IW-1:0] id_of(input int k);
    return IW'(k * 37 + 11);
  endfunction

  always @(posedge clk_dp or negedge rst_dp_n)
    if (!rst_dp_n) pops <= 0;
    else if (alloc_req) pops <= pops + 1;

  task automatic env();
    alloc_valid = $urandom_range(0, 9) < 8;
    wr_ready = $urandom_range(0, 9) < 8;
    desc_ready = $urandom_range(0, 3) != 0;
    alloc_id = id_of(pops);
  endtask

  task automatic cyc();
    @(posedge clk_dp);
    #1;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    cyc();
    rst_dp_n = 1'b0;
    cyc();
    rst_dp_n = 1'b1;
  endtask

  task automatic drive(input logic v, input logic sop, input logic eop, input logic [6:0] b, input logic [IW-1:0] aid);
    in_valid = v; in_sop = sop; in_eop = eop; in_bytes = b; alloc_id = aid;
    in_data = {16{$urandom}};
  endtask

  task automatic rbeat(input logic sop, input logic eop, input logic [6:0] b, input logic [DW-1:0] d);
    int n;
    logic a;
    n = 0;
    in_valid = 1'b1; in_sop = sop; in_eop = eop; in_bytes = b; in_data = d;
    do begin
      @(negedge clk_dp);
      a = in_ready;
      cyc();
      env();
      n++;
    end while (!a && n < 2000);
    if (!a) chk("beat_timeout", 64'd0, 64'd1);
    in_valid = 1'b0;
  endtask

  always @(negedge clk_dp)
    if (mon_en) begin
      chk("alloc_req_eq_wr_valid", alloc_req, wr_valid);
      if (wr_valid) begin
        if (ewr.size() == 0) chk("wr_unexpected", 64'd1, 64'd0);
        else begin
          mw = ewr.pop_front();
          chk("rnd_wr_id", wr_cell_id, mw.id);
          chk("rnd_wr_data", wr_data == mw.d, 1);
          chk("rnd_wr_eof", wr_eof, mw.eof);
        end
      end
      if (lnk_valid) begin
        if (elk.size() == 0) chk("lnk_unexpected", 64'd1, 64'd0);
        else begin
          ml = elk.pop_front();
          chk("rnd_lnk_cell", lnk_cell_id, ml.c);
          chk("rnd_lnk_next", lnk_next_id, ml.n);
        end
      end
      if (desc_valid && desc_ready) begin
        if (eds.size() == 0) chk("desc_unexpected", 64'd1, 64'd0);
        else begin
          md = eds.pop_front();
          chk("rnd_desc_head", desc_head_id, md.h);
          chk("rnd_desc_tail", desc_tail_id, md.t);
          chk("rnd_desc_len", desc_len, md.len);
          chk("rnd_desc_ncells", desc_ncells, md.nc);
          chk("rnd_desc_err", desc_err, md.err);
        end
      end
    end

  initial begin
    alloc_valid = 1'b1; wr_ready = 1'b1;
    #2;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_alloc_req", alloc_req, 0);
    chk("rst_wr_valid", wr_valid, 0);
    chk("rst_lnk_valid", lnk_valid, 0);
    chk("rst_desc_valid", desc_valid, 0);
    chk("rst_desc_err", desc_err, 0);
    chk("rst_desc_len", desc_len, 0);
    chk("rst_desc_ncells", desc_ncells, 0);
    chk("rst_desc_head", desc_head_id, 0);
    chk("rst_stray", stray_cnt, 0);
    cyc();
    rst_dp_n = 1'b1;
    desc_ready = 1'b1;

    tbl[0]  = '{1, 1, 1, 60, 5, 1,  1, 1, 1, 0, 0, 0,    0, 0, 0, 0, 0, 0};
    tbl[1]  = '{0, 0, 0, 64, 5, 1,  0, 0, 0, 1, 5, EOC,  1, 5, 5, 60, 1, 0};
    tbl[2]  = '{1, 1, 0, 64, 7, 1,  1, 1, 0, 0, 0, 0,    0, 0, 0, 0, 0, 0};
    tbl[3]  = '{1, 0, 0, 64, 3, 1,  1, 1, 0, 1, 7, 3,    0, 0, 0, 0, 0, 0};
    tbl[4]  = '{1, 1, 1, 10, 9, 1,  1, 1, 1, 1, 3, 9,    0, 0, 0, 0, 0, 0};
    tbl[5]  = '{0, 0, 0, 64, 9, 1,  0, 0, 0, 1, 9, EOC,  1, 7, 9, 138, 3, 0};
    tbl[6]  = '{1, 1, 0, 64, 20, 1, 1, 1, 0, 0, 0, 0,    0, 0, 0, 0, 0, 0};
    for (int i = 7; i < 11; i++)
      tbl[i] = '{1, 0, 0, 64, 21, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0};
    tbl[11] = '{1, 0, 0, 64, 21, 1, 1, 1, 0, 1, 20, 21,  0, 0, 0, 0, 0, 0};
    tbl[12] = '{1, 0, 1, 64, 22, 1, 1, 1, 1, 1, 21, 22,  0, 0, 0, 0, 0, 0};
    tbl[13] = '{0, 0, 0, 64, 22, 1, 0, 0, 0, 1, 22, EOC, 1, 20, 22, 192, 3, 0};
    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].v, tbl[i].sop, tbl[i].eop, tbl[i].bytes, tbl[i].aid);
      alloc_valid = tbl[i].av;
      @(negedge clk_dp);
      chk($sformatf("t%0d_in_ready", i), in_ready, tbl[i].rdy);
      chk($sformatf("t%0d_wr_valid", i), wr_valid, tbl[i].wr);
      chk($sformatf("t%0d_alloc_req", i), alloc_req, tbl[i].wr);
      if (tbl[i].wr) chk($sformatf("t%0d_wr_eof", i), wr_eof, tbl[i].eof);
      chk($sformatf("t%0d_lnk_valid", i), lnk_valid, tbl[i].lnk);
      if (tbl[i].lnk) begin
        chk($sformatf("t%0d_lnk_cell", i), lnk_cell_id, tbl[i].lc);
        chk($sformatf("t%0d_lnk_next", i), lnk_next_id, tbl[i].ln);
      end
      chk($sformatf("t%0d_desc_valid", i), desc_valid, tbl[i].dv);
      if (tbl[i].dv) begin
        chk($sformatf("t%0d_desc_head", i), desc_head_id, tbl[i].hd);
        chk($sformatf("t%0d_desc_tail", i), desc_tail_id, tbl[i].tl);
        chk($sformatf("t%0d_desc_len", i), desc_len, tbl[i].len);
        chk($sformatf("t%0d_desc_ncells", i), desc_ncells, tbl[i].nc);
        chk($sformatf("t%0d_desc_err", i), desc_err, tbl[i].err);
      end
      cyc();
    end

    desc_ready = 1'b0;
    drive(1, 1, 1, 33, 40);
    @(negedge clk_dp);
    chk("bp_first_wr", wr_valid, 1);
    cyc();
    drive(1, 1, 1, 1, 41);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk_dp);
      chk("bp_desc_valid", desc_valid, 1);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_wr_valid", wr_valid, 0);
      chk("bp_lnk_once", lnk_valid, k == 0);
      chk("bp_head", desc_head_id, 40);
      chk("bp_len", desc_len, 33);
      chk("bp_ncells", desc_ncells, 1);
      cyc();
    end
    desc_ready = 1'b1;
    @(negedge clk_dp);
    chk("bp_handshake", desc_valid, 1);
    cyc();
    @(negedge clk_dp);
    chk("bp_next_ready", in_ready, 1);
    chk("bp_next_wr", wr_valid, 1);
    cyc();
    in_valid = 1'b0;
    @(negedge clk_dp);
    chk("bp_next_desc", desc_valid, 1);
    chk("bp_next_len", desc_len, 1);
    chk("bp_next_head", desc_head_id, 41);
    chk("bp_next_lnk", lnk_next_id, EOC);

    do_reset();
    for (int k = 0; k < 3; k++) begin
      drive(1, 0, k == 1, 64, IW'(70 + k));
      @(negedge clk_dp);
      chk("stray_ready", in_ready, 1);
      chk("stray_no_wr", wr_valid, 0);
      chk("stray_no_alloc", alloc_req, 0);
      cyc();
    end
    in_valid = 1'b0;
    @(negedge clk_dp);
    chk("stray_cnt", stray_cnt, 3);
    cyc();
    drive(1, 1, 0, 64, 60);
    cyc();
    drive(1, 0, 0, 64, 61);
    @(negedge clk_dp);
    chk("mid_wr", wr_valid, 1);
    chk("mid_lnk_next", lnk_next_id, 61);
    #1;
    rst_dp_n = 1'b0;
    #1;
    chk("mr_in_ready", in_ready, 0);
    chk("mr_alloc_req", alloc_req, 0);
    chk("mr_wr_valid", wr_valid, 0);
    chk("mr_lnk_valid", lnk_valid, 0);
    chk("mr_desc_valid", desc_valid, 0);
    chk("mr_desc_err", desc_err, 0);
    chk("mr_tail", desc_tail_id, 0);
    chk("mr_len", desc_len, 0);
    chk("mr_ncells", desc_ncells, 0);
    chk("mr_stray", stray_cnt, 0);
    in_valid = 1'b0;
    cyc();
    rst_dp_n = 1'b1;

    for (int k = 0; k < 4; k++) begin
      drive(1, k == 0, k == 3, 64, IW'(50 + k));
      @(negedge clk_dp);
      chk($sformatf("ov%0d_ready", k), s_in_ready, 1);
      chk($sformatf("ov%0d_wr", k), s_wr_valid, k < 2);
      chk($sformatf("ov%0d_lnk", k), s_lnk_valid, k == 1);
      cyc();
    end
    in_valid = 1'b0;
    @(negedge clk_dp);
    chk("ov_desc_valid", s_desc_valid, 1);
    chk("ov_lnk_tail", s_lnk_valid, 1);
    chk("ov_lnk_cell", s_lnk_cell_id, 51);
    chk("ov_lnk_next", s_lnk_next_id, EOC);
    chk("ov_head", s_desc_head_id, 50);
    chk("ov_tail", s_desc_tail_id, 51);
    chk("ov_len", s_desc_len, 128);
    chk("ov_ncells", s_desc_ncells, 2);
    chk("ov_err", s_desc_err, 1);
    cyc();
    @(negedge clk_dp);
    chk("ov_err_clear", s_desc_err, 0);
    chk("ov_desc_done", s_desc_valid, 0);

    do_reset();
    exp_stray = 0;
    nid = 0;
    env();
    mon_en = 1'b1;
    for (int p = 0; p < 30; p++) begin
      int nb, ns, cnt;
      int unsigned len;
      logic drop;
      logic [IW-1:0] head, prev, id;
      ns = $urandom_range(0, 2);
      for (int s = 0; s < ns; s++) rbeat(1'b0, 1'($urandom_range(0, 1)), 7'd64, {16{$urandom}});
      exp_stray += ns;
      nb = (p % 4 == 0) ? $urandom_range(142, 150) : $urandom_range(1, 6);
      len = 0; cnt = 0; drop = 1'b0; head = '0; prev = '0;
      for (int i = 0; i < nb; i++) begin
        logic eop;
        logic [6:0] b;
        logic [DW-1:0] d;
        eop = i == nb - 1;
        b = eop ? 7'($urandom_range(1, 64)) : 7'd64;
        d = {16{$urandom}};
        if (i == 0 || (!drop && len + b <= MAXL)) begin
          id = id_of(nid);
          nid++;
          if (i == 0) head = id;
          else elk.push_back('{prev, id});
          ewr.push_back('{id, d, eop});
          len += b;
          cnt++;
          prev = id;
        end else drop = 1'b1;
        rbeat(i == 0 ? 1'b1 : 1'($urandom_range(0, 1)), eop, b, d);
      end
      elk.push_back('{prev, EOC});
      eds.push_back('{head, prev, LW'(len), IW'(cnt), drop});
    end
    begin
      int w;
      w = 0;
      while (eds.size() != 0 && w < 5000) begin
        cyc();
        env();
        w++;
      end
    end
    cyc();
    mon_en = 1'b0;
    chk("drain_desc", eds.size(), 0);
    chk("drain_wr", ewr.size(), 0);
    chk("drain_lnk", elk.size(), 0);
    chk("rnd_stray_cnt", stray_cnt, exp_stray);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
